// File: rtl/gpio_wb_pkg.sv
// rtl/gpio_wb_pkg.sv - shared types, widths and GPIO register map for the Wishbone master
package gpio_wb_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_ERR     = 2'd1,
        STAT_TIMEOUT = 2'd2
    } rsp_status_e;

    localparam logic [3:0] GPIO_REG_DATA_OUT = 4'h0;
    localparam logic [3:0] GPIO_REG_DATA_IN  = 4'h1;
    localparam logic [3:0] GPIO_REG_DIR      = 4'h2;
    localparam logic [3:0] GPIO_REG_IRQ_EN   = 4'h3;
    localparam logic [3:0] GPIO_REG_IRQ_STAT = 4'h4;

    // Bus-cycle outcome when several terminations coincide: err beats ack beats watchdog.
    function automatic rsp_status_e resolve_status(input logic ack, input logic err);
        rsp_status_e s;
        if (err) begin
            s = STAT_ERR;
        end else if (ack) begin
            s = STAT_OK;
        end else begin
            s = STAT_TIMEOUT;
        end
        return s;
    endfunction

endpackage

// File: rtl/gpio_wb_watchdog.sv
// rtl/gpio_wb_watchdog.sv - saturating bus-cycle watchdog, expires on the TIMEOUT-th enabled cycle
module gpio_wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/gpio_wb_master.sv
// rtl/gpio_wb_master.sv - single-outstanding Wishbone classic master with watchdog-bounded cycles
module gpio_wb_master
    import gpio_wb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    state_e            state_q,   state_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] adr_q,     adr_d;
    logic [DATA_W-1:0] dat_q,     dat_d;
    logic [SEL_W-1:0]  sel_q,     sel_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    rsp_status_e       status_q,  status_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    gpio_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        status_d  = status_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d     = cmd_we_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    sel_d    = cmd_sel_i;
                    wd_clear = 1'b1;
                    state_d  = BUS;
                end
            end
            BUS: begin
                wd_enable = 1'b1;
                if (wb_err_i || wb_ack_i || wd_expire) begin
                    status_d = resolve_status(wb_ack_i, wb_err_i);
                    // Only a successful read returns bus data; writes, errors and timeouts report zero.
                    if (!wb_err_i && wb_ack_i && !we_q) begin
                        rsp_dat_d = wb_dat_i;
                    end else begin
                        rsp_dat_d = '0;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            status_q  <= STAT_OK;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            status_q  <= status_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign wb_cyc_o      = (state_q == BUS);
    assign wb_stb_o      = (state_q == BUS);
    assign rsp_valid_o   = (state_q == RESP);

    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;

    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = (status_q == STAT_ERR);
    assign rsp_timeout_o = (status_q == STAT_TIMEOUT);

endmodule
